// File: rtl/rf_write_scheduler.sv
// Round-robin scheduler for the single register-file write port (wb vs fill) plus a
// 16-entry pending-write scoreboard. Define RF_WRITE_CNT_EN to add per-requester accept counters.
module rf_write_scheduler #(
   parameter int DATA_W = 16,
   parameter int ID_W   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rsv_valid,
   input  logic [ID_W-1:0]      rsv_id,
   output logic                 rsv_ready,
   input  logic                 wb_valid,
   input  logic [ID_W-1:0]      wb_id,
   input  logic [DATA_W-1:0]    wb_data,
   output logic                 wb_ready,
   input  logic                 fill_valid,
   input  logic [ID_W-1:0]      fill_id,
   input  logic [DATA_W-1:0]    fill_data,
   output logic                 fill_ready,
   input  logic [ID_W-1:0]      src1_id,
   input  logic [ID_W-1:0]      src2_id,
   output logic                 src_busy,
   output logic [(2**ID_W)-1:0] busy_vec,
`ifdef RF_WRITE_CNT_EN
   output logic [15:0]          wr_cnt_wb,
   output logic [15:0]          wr_cnt_fill,
`endif
   output logic                 WriteReg,
   output logic [ID_W-1:0]      DstReg,
   output logic [DATA_W-1:0]    DstData
);

   localparam int   NREG       = 2**ID_W;
   localparam logic GRANT_WB   = 1'b0;
   localparam logic GRANT_FILL = 1'b1;

   logic              last_grant;
   logic              acc_wb;
   logic              acc_fill;
   logic              acc;
   logic [ID_W-1:0]   acc_id;
   logic [DATA_W-1:0] acc_data;
   logic [NREG-1:0]   set_mask;
   logic [NREG-1:0]   clr_mask;

   // Handshake: a transfer occurs at a clk edge where valid & ready are both high; the
   // requester holds valid/id/data stable until then. Ties go opposite last_grant.
   assign wb_ready   = wb_valid   & (~fill_valid | (last_grant == GRANT_FILL));
   assign fill_ready = fill_valid & (~wb_valid   | (last_grant == GRANT_WB));
   assign acc_wb     = wb_valid & wb_ready;
   assign acc_fill   = fill_valid & fill_ready;
   assign acc        = acc_wb | acc_fill;

   // busy_vec[0] is never set, so R0 reservations are always ready.
   assign rsv_ready = ~busy_vec[rsv_id];
   assign src_busy  = ((src1_id != '0) & busy_vec[src1_id]) |
                      ((src2_id != '0) & busy_vec[src2_id]);

   always_comb begin
      acc_id   = wb_id;
      acc_data = wb_data;
      if (acc_fill) begin
         acc_id   = fill_id;
         acc_data = fill_data;
      end
      set_mask = '0;
      clr_mask = '0;
      if (rsv_valid && rsv_ready && (rsv_id != '0)) set_mask[rsv_id] = 1'b1;
      if (acc) clr_mask[acc_id] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_vec   <= '0;
         last_grant <= GRANT_FILL;
         WriteReg   <= 1'b0;
         DstReg     <= '0;
         DstData    <= '0;
      end else begin
         busy_vec <= (busy_vec & ~clr_mask) | set_mask;
         // R0 is hardwired: the accept completes but no write enable is issued.
         WriteReg <= acc && (acc_id != '0);
         if (acc) begin
            DstReg     <= acc_id;
            DstData    <= acc_data;
            last_grant <= acc_fill ? GRANT_FILL : GRANT_WB;
         end
      end
   end

`ifdef RF_WRITE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_wb   <= '0;
         wr_cnt_fill <= '0;
      end else begin
         if (acc_wb && (wr_cnt_wb != 16'hFFFF))     wr_cnt_wb   <= wr_cnt_wb + 16'd1;
         if (acc_fill && (wr_cnt_fill != 16'hFFFF)) wr_cnt_fill <= wr_cnt_fill + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed + randomized bench for rf_write_scheduler; a negedge monitor scoreboards the write port.
module tb_rf_write_scheduler;

   localparam int DATA_W = 16;
   localparam int ID_W   = 4;

   logic              clk;
   logic              rst_n;
   logic              rsv_valid;
   logic [ID_W-1:0]   rsv_id;
   logic              rsv_ready;
   logic              wb_valid;
   logic [ID_W-1:0]   wb_id;
   logic [DATA_W-1:0] wb_data;
   logic              wb_ready;
   logic              fill_valid;
   logic [ID_W-1:0]   fill_id;
   logic [DATA_W-1:0] fill_data;
   logic              fill_ready;
   logic [ID_W-1:0]   src1_id;
   logic [ID_W-1:0]   src2_id;
   logic              src_busy;
   logic [15:0]       busy_vec;
   logic              WriteReg;
   logic [ID_W-1:0]   DstReg;
   logic [DATA_W-1:0] DstData;
`ifdef RF_WRITE_CNT_EN
   logic [15:0]       wr_cnt_wb;
   logic [15:0]       wr_cnt_fill;
   logic [15:0]       m_cnt_wb;
   logic [15:0]       m_cnt_fill;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [ID_W+DATA_W-1:0] exp_q[$];
   logic [ID_W+DATA_W-1:0] exp_e;
   logic w_acc;
   logic f_acc;

   rf_write_scheduler #(.DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .rsv_valid(rsv_valid), .rsv_id(rsv_id), .rsv_ready(rsv_ready),
      .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_ready(wb_ready),
      .fill_valid(fill_valid), .fill_id(fill_id), .fill_data(fill_data), .fill_ready(fill_ready),
      .src1_id(src1_id), .src2_id(src2_id), .src_busy(src_busy), .busy_vec(busy_vec),
`ifdef RF_WRITE_CNT_EN
      .wr_cnt_wb(wr_cnt_wb), .wr_cnt_fill(wr_cnt_fill),
`endif
      .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout, required $finish before limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rsv_valid  = 1'b0;
      wb_valid   = 1'b0;
      fill_valid = 1'b0;
   endtask

   // scoreboard: push at the negedge before an accepting edge, pop one negedge later
   always @(negedge rst_n) begin
      exp_q.delete();
`ifdef RF_WRITE_CNT_EN
      m_cnt_wb   = '0;
      m_cnt_fill = '0;
`endif
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("wr_en", 32'(WriteReg), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            exp_e = exp_q.pop_front();
            if (WriteReg) begin
               check("wr_id", 32'(DstReg), 32'(exp_e[ID_W+DATA_W-1:DATA_W]));
               check("wr_data", 32'(DstData), 32'(exp_e[DATA_W-1:0]));
            end
         end
         check("one_ready", 32'(wb_ready & fill_ready), 32'(0));
`ifdef RF_WRITE_CNT_EN
         check("cnt_wb", 32'(wr_cnt_wb), 32'(m_cnt_wb));
         check("cnt_fill", 32'(wr_cnt_fill), 32'(m_cnt_fill));
         if (wb_valid && wb_ready && m_cnt_wb != 16'hFFFF) m_cnt_wb = m_cnt_wb + 16'd1;
         if (fill_valid && fill_ready && m_cnt_fill != 16'hFFFF) m_cnt_fill = m_cnt_fill + 16'd1;
`endif
         if (wb_valid && wb_ready) begin
            if (wb_id != '0) exp_q.push_back({wb_id, wb_data});
         end else if (fill_valid && fill_ready) begin
            if (fill_id != '0) exp_q.push_back({fill_id, fill_data});
         end
      end else begin
         exp_q.delete();
      end
   end

   initial begin
      rst_n = 1'b0;
      idle();
      rsv_id = '0; wb_id = '0; wb_data = '0; fill_id = '0; fill_data = '0;
      src1_id = '0; src2_id = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("rst_busy", 32'(busy_vec), 32'h0);
      check("rst_wr", 32'(WriteReg), 32'h0);
      check("rst_dst", 32'(DstReg), 32'h0);
      check("rst_data", 32'(DstData), 32'h0);

      // contention straight after reset: wb wins the first tie
      wb_valid = 1; wb_id = 4'd3; wb_data = 16'h1111;
      fill_valid = 1; fill_id = 4'd4; fill_data = 16'h2222;
      #1;
      check("tie_wb_ready", 32'(wb_ready), 32'h1);
      check("tie_fill_ready", 32'(fill_ready), 32'h0);
      tick();
      check("c1_wr", 32'(WriteReg), 32'h1);
      check("c1_dst", 32'(DstReg), 32'h3);
      check("c1_data", 32'(DstData), 32'h1111);
      wb_valid = 0;
      #1;
      check("c2_fill_ready", 32'(fill_ready), 32'h1);
      tick();
      check("c2_wr", 32'(WriteReg), 32'h1);
      check("c2_dst", 32'(DstReg), 32'h4);
      check("c2_data", 32'(DstData), 32'h2222);
      fill_valid = 0;
      tick();
      check("c3_wr", 32'(WriteReg), 32'h0);

      // after a wb accept, fill wins the next tie
      wb_valid = 1; wb_id = 4'd2; wb_data = 16'hA0A0;
      tick();
      wb_id = 4'd10; wb_data = 16'h0A0A;
      fill_valid = 1; fill_id = 4'd6; fill_data = 16'h6060;
      #1;
      check("rr_fill_ready", 32'(fill_ready), 32'h1);
      check("rr_wb_ready", 32'(wb_ready), 32'h0);
      tick();
      fill_valid = 0;
      #1;
      check("rr_wb_ready2", 32'(wb_ready), 32'h1);
      tick();
      wb_valid = 0;
      tick();

      // reservation and write of id5
      rsv_valid = 1; rsv_id = 4'd5;
      #1;
      check("rsv5_ready", 32'(rsv_ready), 32'h1);
      tick();
      rsv_valid = 0;
      check("rsv5_busy", 32'(busy_vec), 32'h0020);
      src1_id = 4'd5;
      #1;
      check("src1_busy", 32'(src_busy), 32'h1);
      src1_id = 4'd0; src2_id = 4'd5;
      #1;
      check("src2_busy", 32'(src_busy), 32'h1);
      src2_id = 4'd0; src1_id = 4'd5;
      rsv_valid = 1;
      #1;
      check("rsv5_again", 32'(rsv_ready), 32'h0);
      tick();
      rsv_valid = 0;
      check("rsv5_hold", 32'(busy_vec), 32'h0020);
      wb_valid = 1; wb_id = 4'd5; wb_data = 16'hBEEF;
      #1;
      check("wb5_ready", 32'(wb_ready), 32'h1);
      tick();
      wb_valid = 0;
      check("wb5_busy", 32'(busy_vec), 32'h0);
      check("wb5_src_busy", 32'(src_busy), 32'h0);
      check("wb5_wr", 32'(WriteReg), 32'h1);
      check("wb5_dst", 32'(DstReg), 32'h5);
      check("wb5_data", 32'(DstData), 32'hBEEF);
      tick();
      check("wb5_wr_off", 32'(WriteReg), 32'h0);
      src1_id = 4'd0;

      // R0 handling
      rsv_valid = 1; rsv_id = 4'd2;
      tick();
      check("rsv2_busy", 32'(busy_vec), 32'h0004);
      rsv_id = 4'd0;
      #1;
      check("rsv0_ready", 32'(rsv_ready), 32'h1);
      tick();
      rsv_valid = 0;
      check("rsv0_busy", 32'(busy_vec), 32'h0004);
      wb_valid = 1; wb_id = 4'd0; wb_data = 16'h1234;
      #1;
      check("r0_ready", 32'(wb_ready), 32'h1);
      tick();
      wb_valid = 0;
      check("r0_wr", 32'(WriteReg), 32'h0);
      check("r0_dst", 32'(DstReg), 32'h0);
      check("r0_data", 32'(DstData), 32'h1234);
      check("r0_busy", 32'(busy_vec), 32'h0004);

      // clear/reserve interplay on id7
      rsv_valid = 1; rsv_id = 4'd7;
      tick();
      check("rsv7_busy", 32'(busy_vec), 32'h0084);
      fill_valid = 1; fill_id = 4'd7; fill_data = 16'h7777;
      #1;
      check("rsv7_stall", 32'(rsv_ready), 32'h0);
      check("fill7_ready", 32'(fill_ready), 32'h1);
      tick();
      fill_valid = 0;
      check("fill7_clr", 32'(busy_vec), 32'h0004);
      #1;
      check("rsv7_retry", 32'(rsv_ready), 32'h1);
      tick();
      rsv_valid = 0;
      check("rsv7_set", 32'(busy_vec), 32'h0084);

      // set id9 and clear id7 at the same edge
      rsv_valid = 1; rsv_id = 4'd9;
      wb_valid = 1; wb_id = 4'd7; wb_data = 16'h0707;
      tick();
      rsv_valid = 0; wb_valid = 0;
      check("set_clr_busy", 32'(busy_vec), 32'h0204);
      fill_valid = 1; fill_id = 4'd9; fill_data = 16'h0909;
      tick();
      fill_valid = 0;
      wb_valid = 1; wb_id = 4'd2; wb_data = 16'h0202;
      tick();
      wb_valid = 0;
      check("drain_busy", 32'(busy_vec), 32'h0);

      // asynchronous reset mid-operation with busy_vec = 0x00A0
      rsv_valid = 1; rsv_id = 4'd5;
      tick();
      rsv_id = 4'd7;
      tick();
      rsv_valid = 0;
      check("pre_rst_busy", 32'(busy_vec), 32'h00A0);
      wb_valid = 1; wb_id = 4'd3; wb_data = 16'h5555;
      tick();
      wb_valid = 0;
      check("pre_rst_wr", 32'(WriteReg), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy_vec), 32'h0);
      check("mid_rst_wr", 32'(WriteReg), 32'h0);
      check("mid_rst_dst", 32'(DstReg), 32'h0);
      check("mid_rst_data", 32'(DstData), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wb_valid = 1; wb_id = 4'd11; wb_data = 16'hB0B0;
      fill_valid = 1; fill_id = 4'd12; fill_data = 16'hC0C0;
      #1;
      check("post_rst_wb", 32'(wb_ready), 32'h1);
      check("post_rst_fill", 32'(fill_ready), 32'h0);
      tick();
      wb_valid = 0;
      tick();
      fill_valid = 0;
      tick();

      // randomized traffic, each request held until accepted
      for (int i = 0; i < 80; i++) begin
         if (!wb_valid && $urandom_range(0, 1) != 0) begin
            wb_valid = 1;
            wb_id    = 4'($urandom_range(0, 15));
            wb_data  = 16'($urandom_range(0, 65535));
         end
         if (!fill_valid && $urandom_range(0, 1) != 0) begin
            fill_valid = 1;
            fill_id    = 4'($urandom_range(0, 15));
            fill_data  = 16'($urandom_range(0, 65535));
         end
         #1;
         w_acc = wb_valid & wb_ready;
         f_acc = fill_valid & fill_ready;
         tick();
         if (w_acc) wb_valid = 0;
         if (f_acc) fill_valid = 0;
      end
      idle();
      repeat (2) tick();

`ifdef RF_WRITE_CNT_EN
      // drive the wb counter into saturation with R0 accepts
      wb_valid = 1; wb_id = 4'd0; wb_data = 16'h0;
      repeat (65540) tick();
      wb_valid = 0;
      tick();
      check("cnt_wb_sat", 32'(wr_cnt_wb), 32'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
